// File: rtl/truth_table_sampler_pkg.sv
// truth_table_sampler_pkg: shared FSM states, sweep geometry and row-to-bit mapping
package tt_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   localparam int ROW_W    = 3;
   localparam int NUM_ROWS = 8;
   localparam int VOTES    = 3;
   function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] row);
      return ROW_W'(NUM_ROWS - 1) - row;
   endfunction
endpackage

// File: rtl/truth_table_sampler_if.sv
// truth_table_sampler_if: stimulus/capture bus between the sampler and its environment
interface truth_table_sampler_if;
   logic       start;
   logic       circ_out;
   logic       in1;
   logic       in2;
   logic       in3;
   logic       busy;
   logic       done;
   logic [7:0] tt;
   logic       pass;
   logic [7:0] mismatch;
   modport master (output start, circ_out, input in1, in2, in3, busy, done, tt, pass, mismatch);
   modport slave  (input start, circ_out, output in1, in2, in3, busy, done, tt, pass, mismatch);
endinterface

// File: rtl/truth_table_sampler_sample_voter.sv
// sample_voter: accumulates VOTES samples and reports the running majority
module sample_voter
   import tt_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   input  logic d,
   output logic vote,
   output logic last
);
   logic [1:0] ones;
   logic [1:0] cnt;
   // vote includes the current sample so the decision lands on the final sample edge
   assign vote = (ones + {1'b0, d}) >= 2'd2;
   assign last = cnt == 2'(VOTES - 1);
   // count samples and ones while enabled; cleared outside the sampling window
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         ones <= '0;
         cnt  <= '0;
      end else if (en) begin
         ones <= ones + {1'b0, d};
         cnt  <= cnt + 2'd1;
      end
   end
endmodule

// File: rtl/truth_table_sampler.sv
// truth_table_sampler: sweeps a 3-input circuit through all rows and captures its truth table
module truth_table_sampler
   import tt_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 16,
   parameter logic [7:0] EXPECTED      = 8'h57
)(
   input logic                  clk,
   input logic                  reset,
   truth_table_sampler_if.slave bus
);
   state_t           state;
   logic [ROW_W-1:0] row;
   logic [15:0]      settle_cnt;
   logic             vote;
   logic             last;
   logic [7:0]       tt_next;
   sample_voter u_voter (
      .clk   (clk),
      .rst   (reset),
      .clear (state != SAMPLE),
      .en    (state == SAMPLE),
      .d     (bus.circ_out),
      .vote  (vote),
      .last  (last)
   );
   // truth table with the current row's majority merged in
   always_comb begin
      tt_next = bus.tt;
      tt_next[row_to_bit(row)] = vote;
   end
   // sweep FSM; inputs only change on the edge leaving SAMPLE or DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         state                        <= IDLE;
         row                          <= '0;
         settle_cnt                   <= '0;
         {bus.in1, bus.in2, bus.in3}  <= '0;
         bus.busy                     <= 1'b0;
         bus.done                     <= 1'b0;
         bus.tt                       <= '0;
         bus.pass                     <= 1'b0;
         bus.mismatch                 <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               state                       <= SETTLE;
               row                         <= '0;
               settle_cnt                  <= '0;
               {bus.in1, bus.in2, bus.in3} <= '0;
               bus.busy                    <= 1'b1;
               bus.tt                      <= '0;
               bus.pass                    <= 1'b0;
               bus.mismatch                <= '0;
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 16'd1;
               if (settle_cnt == 16'(SETTLE_CYCLES - 1)) state <= SAMPLE;
            end
            SAMPLE: if (last) begin
               bus.tt <= tt_next;
               if (row == ROW_W'(NUM_ROWS - 1)) begin
                  state        <= DONE;
                  bus.done     <= 1'b1;
                  bus.pass     <= tt_next == EXPECTED;
                  bus.mismatch <= tt_next ^ EXPECTED;
               end else begin
                  state                       <= SETTLE;
                  row                         <= row + 1'b1;
                  settle_cnt                  <= '0;
                  {bus.in1, bus.in2, bus.in3} <= row + 1'b1;
               end
            end
            DONE: begin
               state                       <= IDLE;
               bus.busy                    <= 1'b0;
               {bus.in1, bus.in2, bus.in3} <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
